// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter: 64 SCLK per frame (32 per channel slot), 16-bit words
// sent MSB first one SCLK after each LRCK edge, with a per-frame sample_ce pulse.
module audio_i2s_tx #(
  parameter int unsigned DIV = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] input_l,
  input  logic [15:0] input_r,
  input  logic        mute,
  output logic        sample_ce,
  output logic        i2s_sclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        sclk_q, sclk_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        lrck_q, lrck_d;
  logic        sdata_q, sdata_d;
  logic        sample_ce_q, sample_ce_d;
  logic [15:0] hold_l_q, hold_l_d;
  logic [15:0] hold_r_q, hold_r_d;

  logic        fall;
  logic [5:0]  bit_next;
  logic [15:0] cur_l, cur_r;

  always_comb begin
    div_cnt_d   = div_cnt_q;
    sclk_d      = sclk_q;
    bit_cnt_d   = bit_cnt_q;
    lrck_d      = lrck_q;
    sdata_d     = sdata_q;
    sample_ce_d = 1'b0;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    fall        = 1'b0;
    bit_next    = bit_cnt_q + 6'd1;
    cur_l       = hold_l_q;
    cur_r       = hold_r_q;

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
      fall      = sclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 8'd1;
    end

    if (fall) begin
      bit_cnt_d = bit_next;
      lrck_d    = bit_next[5];
      if (bit_next == '0) begin
        cur_l       = mute ? '0 : input_l;
        cur_r       = mute ? '0 : input_r;
        hold_l_d    = cur_l;
        hold_r_d    = cur_r;
        sample_ce_d = 1'b1;
      end
      // The old bit_cnt is the serial position p; 15-p and 47-p both reduce to ~p[3:0].
      unique case (bit_cnt_q[5:4])
        2'b00:   sdata_d = cur_l[~bit_cnt_q[3:0]];
        2'b10:   sdata_d = cur_r[~bit_cnt_q[3:0]];
        default: sdata_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      bit_cnt_q   <= '1;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      sample_ce_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      sclk_q      <= sclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      sample_ce_q <= sample_ce_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
    end
  end

  assign sample_ce = sample_ce_q;
  assign i2s_sclk  = sclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: DIV=2 and DIV=1 instances checked against a closed-form
// model that derives every output from the clk count since reset release.
module tb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_l = '0;
  logic [15:0] in_r = '0;
  logic        mute = 1'b0;

  logic ce0, sclk0, lrck0, sd0;
  logic ce1, sclk1, lrck1, sd1;

  always #5 clk = ~clk;

  audio_i2s_tx #(.DIV(2)) dut (
    .clk(clk), .reset(reset), .input_l(in_l), .input_r(in_r), .mute(mute),
    .sample_ce(ce0), .i2s_sclk(sclk0), .i2s_lrck(lrck0), .i2s_sdata(sd0)
  );

  audio_i2s_tx #(.DIV(1)) dut1 (
    .clk(clk), .reset(reset), .input_l(in_l), .input_r(in_r), .mute(mute),
    .sample_ce(ce1), .i2s_sclk(sclk1), .i2s_lrck(lrck1), .i2s_sdata(sd1)
  );

  int vectors = 0;
  int errors  = 0;

  int          divs [2] = '{2, 1};
  int          n    [2];
  int          e_bc [2];
  logic        e_fall [2];
  logic [3:0]  exp_o [2];
  logic [15:0] mh_l [2];
  logic [15:0] mh_r [2];

  function automatic logic [3:0] obs(input int m);
    return (m == 0) ? {sclk0, lrck0, sd0, ce0} : {sclk1, lrck1, sd1, ce1};
  endfunction

  // Clk n (0 = first edge after release): SCLK has toggled floor((n+1)/DIV) times,
  // falls = floor((n+1)/(2*DIV)), bit_cnt = falls-1 mod 64.
  task automatic model_step(input int m);
    int d, f, bc, p;
    logic s, fl, sd, ce;
    d = divs[m];
    e_fall[m] = 1'b0;
    if (reset) begin
      n[m] = -1; mh_l[m] = '0; mh_r[m] = '0; e_bc[m] = 63; exp_o[m] = '0;
    end else begin
      n[m]++;
      s  = (((n[m] + 1) / d) % 2) == 1;
      f  = (n[m] + 1) / (2 * d);
      fl = ((n[m] + 1) % (2 * d)) == 0;
      if (f == 0) begin
        e_bc[m] = 63; exp_o[m] = {s, 3'b000};
      end else begin
        bc = (f - 1) % 64;
        ce = fl && (bc == 0);
        if (ce) begin
          mh_l[m] = mute ? 16'h0 : in_l;
          mh_r[m] = mute ? 16'h0 : in_r;
        end
        p = (bc + 63) % 64;
        if (p < 16)                sd = mh_l[m][15 - p];
        else if (p >= 32 && p < 48) sd = mh_r[m][47 - p];
        else                       sd = 1'b0;
        e_bc[m] = bc; e_fall[m] = fl;
        exp_o[m] = {s, (bc >= 32), sd, ce};
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic run_until(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      cycle();
      if (e_fall[0] && e_bc[0] == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if (obs(m) !== 4'b0000) begin
        errors++; $display("FAIL reset_state inst%0d got %b want 0000", m, obs(m));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_timing();
    int ce_t0[$], ce_t1[$];
    int rise0, fall0;
    logic prev;
    rise0 = -1; fall0 = -1; prev = 1'b0;
    in_l = 16'($urandom); in_r = 16'($urandom);
    for (int i = 0; i < 530; i++) begin
      cycle();
      for (int m = 0; m < 2; m++) begin
        vectors++;
        if (obs(m) !== exp_o[m]) begin
          errors++;
          $display("FAIL timing_model inst%0d n=%0d got %b want %b", m, n[m], obs(m), exp_o[m]);
        end
      end
      if (sclk0 && !prev && rise0 < 0) rise0 = n[0];
      if (!sclk0 && prev && fall0 < 0) fall0 = n[0];
      prev = sclk0;
      if (ce0) ce_t0.push_back(n[0]);
      if (ce1) ce_t1.push_back(n[1]);
    end
    vectors++;
    if (rise0 !== 1 || fall0 !== 3) begin
      errors++; $display("FAIL first_sclk rise=%0d fall=%0d want 1 3", rise0, fall0);
    end
    vectors++;
    if (ce_t0.size() < 3) begin
      errors++; $display("FAIL ce_count div2 got %0d want >=3", ce_t0.size());
    end else if (ce_t0[0] != 3 || ce_t0[1] != 259 || ce_t0[2] != 515) begin
      errors++;
      $display("FAIL ce_times div2 got %0d %0d %0d want 3 259 515", ce_t0[0], ce_t0[1], ce_t0[2]);
    end
    vectors++;
    if (ce_t1.size() < 3) begin
      errors++; $display("FAIL ce_count div1 got %0d want >=3", ce_t1.size());
    end else if (ce_t1[0] != 1 || ce_t1[1] - ce_t1[0] != 128 || ce_t1[2] - ce_t1[1] != 128) begin
      errors++;
      $display("FAIL ce_times div1 got %0d %0d %0d want 1 129 257", ce_t1[0], ce_t1[1], ce_t1[2]);
    end
  endtask

  task automatic test_pattern();
    bit ok;
    logic [15:0] wl, wr;
    logic pad;
    wl = '0; wr = '0; pad = 1'b0;
    in_l = 16'h8001; in_r = 16'h7FFE; mute = 1'b0;
    run_until(0, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL pattern_wait timeout got 0 want 1"); end
    for (int i = 0; i < 300; i++) begin
      cycle();
      for (int m = 0; m < 2; m++) begin
        vectors++;
        if (obs(m) !== exp_o[m]) begin
          errors++;
          $display("FAIL pattern_model inst%0d n=%0d got %b want %b", m, n[m], obs(m), exp_o[m]);
        end
      end
      if (e_fall[0]) begin
        if (e_bc[0] >= 1 && e_bc[0] <= 16)       wl = {wl[14:0], sd0};
        else if (e_bc[0] >= 33 && e_bc[0] <= 48) wr = {wr[14:0], sd0};
        else                                     pad = pad | sd0;
        vectors++;
        if (lrck0 !== (e_bc[0] >= 32)) begin
          errors++; $display("FAIL pattern_lrck bc=%0d got %b want %b", e_bc[0], lrck0, e_bc[0] >= 32);
        end
        if (e_bc[0] == 63) break;
      end
    end
    vectors++;
    if (wl !== 16'h8001 || wr !== 16'h7FFE || pad !== 1'b0) begin
      errors++; $display("FAIL pattern_words got %h %h pad=%b want 8001 7ffe pad=0", wl, wr, pad);
    end
  endtask

  task automatic test_mute();
    bit ok;
    logic any1;
    int cl, cr;
    any1 = 1'b0; cl = 0; cr = 0;
    in_l = 16'hFFFF; in_r = 16'hFFFF; mute = 1'b0;
    run_until(63, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL mute_wait timeout got 0 want 1"); end
    repeat (3) cycle();
    mute = 1'b1;
    cycle();
    mute = 1'b0;
    vectors++;
    if (ce0 !== 1'b1) begin errors++; $display("FAIL mute_latch_ce got %b want 1", ce0); end
    for (int fr = 0; fr < 2; fr++) begin
      for (int i = 0; i < 300; i++) begin
        cycle();
        for (int m = 0; m < 2; m++) begin
          vectors++;
          if (obs(m) !== exp_o[m]) begin
            errors++;
            $display("FAIL mute_model inst%0d n=%0d got %b want %b", m, n[m], obs(m), exp_o[m]);
          end
        end
        if (e_fall[0]) begin
          if (fr == 0) any1 = any1 | sd0;
          else if (e_bc[0] >= 1 && e_bc[0] <= 32) cl += int'(sd0);
          else if (e_bc[0] >= 33)                 cr += int'(sd0);
          if (e_bc[0] == 63) break;
        end
      end
    end
    vectors++;
    if (any1 !== 1'b0) begin errors++; $display("FAIL mute_frame got sdata=1 want all 0"); end
    vectors++;
    if (cl != 16 || cr != 16) begin
      errors++; $display("FAIL unmute_ones got %0d %0d want 16 16", cl, cr);
    end
  endtask

  task automatic test_midframe();
    bit ok;
    logic [15:0] w [2];
    in_l = 16'h1234; in_r = 16'($urandom); mute = 1'b0;
    run_until(0, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL mid_wait timeout got 0 want 1"); end
    for (int fr = 0; fr < 2; fr++) begin
      w[fr] = '0;
      for (int i = 0; i < 300; i++) begin
        cycle();
        for (int m = 0; m < 2; m++) begin
          vectors++;
          if (obs(m) !== exp_o[m]) begin
            errors++;
            $display("FAIL mid_model inst%0d n=%0d got %b want %b", m, n[m], obs(m), exp_o[m]);
          end
        end
        if (e_fall[0]) begin
          if (e_bc[0] >= 1 && e_bc[0] <= 16) w[fr] = {w[fr][14:0], sd0};
          if (fr == 0 && e_bc[0] == 10) in_l = 16'hABCD;
          if (e_bc[0] == 63) break;
        end
      end
    end
    vectors++;
    if (w[0] !== 16'h1234 || w[1] !== 16'hABCD) begin
      errors++; $display("FAIL mid_change got %h %h want 1234 abcd", w[0], w[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int first_ce;
    first_ce = -1;
    run_until(40, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL rstmid_wait timeout got 0 want 1"); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if (obs(m) !== 4'b0000) begin
        errors++; $display("FAIL rstmid_state inst%0d got %b want 0000", m, obs(m));
      end
    end
    for (int i = 0; i < 300; i++) begin
      cycle();
      for (int m = 0; m < 2; m++) begin
        vectors++;
        if (obs(m) !== exp_o[m]) begin
          errors++;
          $display("FAIL rstmid_model inst%0d n=%0d got %b want %b", m, n[m], obs(m), exp_o[m]);
        end
      end
      if (ce0 && first_ce < 0) first_ce = n[0];
    end
    vectors++;
    if (first_ce != 3) begin errors++; $display("FAIL rstmid_ce got %0d want 3", first_ce); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) in_l = 16'($urandom);
      if ($urandom_range(0, 7) == 0) in_r = 16'($urandom);
      mute = ($urandom_range(0, 9) == 0);
      cycle();
      for (int m = 0; m < 2; m++) begin
        vectors++;
        if (obs(m) !== exp_o[m]) begin
          errors++;
          $display("FAIL random_model inst%0d n=%0d got %b want %b", m, n[m], obs(m), exp_o[m]);
        end
      end
    end
    mute = 1'b0;
  endtask

  initial begin
    n[0] = -1; n[1] = -1;
    @(negedge clk);
    test_reset();
    test_timing();
    test_pattern();
    test_mute();
    test_midframe();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter DIV, default 12: clk cycles per SCLK half-period; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port input_l, input, 16 bits: signed left sample (filter output_l).
REQ-005 SHALL have port input_r, input, 16 bits: signed right sample (filter output_r).
REQ-006 SHALL have port mute, input, 1 bit: when high, zeros are latched instead of input samples.
REQ-007 SHALL have port sample_ce, output, 1 bit: one-clk pulse per frame; drives the filter's sample_ce.
REQ-008 SHALL have port i2s_sclk, output, 1 bit: serial bit clock.
REQ-009 SHALL have port i2s_lrck, output, 1 bit: word select; 0 = left, 1 = right.
REQ-010 SHALL have port i2s_sdata, output, 1 bit: serial data, Philips I2S format.

Function
REQ-011 SHALL register every output; no combinational path from input to output.
REQ-012 SHALL run div_cnt 0..DIV-1; at DIV-1 it wraps to 0 and toggles i2s_sclk (SCLK event); otherwise it increments.
REQ-013 SHALL treat a toggle 1->0 as a falling event; all lrck, sdata, bit_cnt and latch updates occur only on the clk of a falling event.
REQ-014 SHALL keep bit_cnt 0..63 (6 bits), incremented modulo 64 on each falling event (63 wraps to 0).
REQ-015 SHALL set i2s_lrck = new bit_cnt[5] on each falling event: 32 SCLK per channel slot, 64 per frame.
REQ-016 SHALL latch hold_l/hold_r on the falling event where new bit_cnt = 0: values come from input_l/input_r, or 0 when mute is high that clk.
REQ-017 SHALL pulse sample_ce high for exactly that one clk, once per 128*DIV clk cycles.
REQ-018 SHALL drive i2s_sdata on each falling event as follows, with p = (new bit_cnt - 1) mod 64:
  - p 0..15: hold_l[15-p]
  - p 32..47: hold_r[47-p]
  - otherwise: 0
  - MSB therefore lags each lrck transition by one SCLK.
REQ-019 SHALL use the newly latched hold values on the same falling event as the latch.
  - At bit_cnt = 0, sdata = 0 (padding position p = 63).
REQ-020 SHALL leave i2s_lrck and i2s_sdata stable across rising SCLK events (the receiver samples on rising).
REQ-021 SHALL ignore input and mute changes on all clks other than the latch clk.

Reset
REQ-022 SHALL, on any clk with reset high, set:
  - div_cnt = 0, bit_cnt = 63
  - i2s_sclk = 0, i2s_lrck = 0, i2s_sdata = 0
  - sample_ce = 0, hold_l = hold_r = 0
REQ-023 SHALL honour reset mid-frame with no partial word completing afterward; reset has priority over all other updates.
REQ-024 SHALL, after release at clk 0, produce:
  - first rising SCLK at clk DIV-1
  - first falling event and first sample_ce at clk 2*DIV-1, with bit_cnt going to 0

Verification
REQ-025 DIV=2, reset released -> i2s_sclk rises at clk 1, falls at clk 3; sample_ce pulses at clk 3, 259, 515 (period 256); lrck toggles every 128 clks.
REQ-026 DIV=2, input_l=0x8001, input_r=0x7FFE held -> sdata over falling events bit_cnt 1..16 = 1,0x14,1; 17..32 = 0; 33..48 = 0,1x14,0; 49..63 = 0; lrck 0 for bit_cnt 0..31, 1 for 32..63.
REQ-027 mute high only at latch clk, inputs 0xFFFF/0xFFFF -> entire frame sdata = 0; next frame with mute low -> 16 ones per slot.
REQ-028 input_l changed from 0x1234 to 0xABCD mid-frame (bit_cnt=10) -> current frame still shifts 0x1234; next frame shifts 0xABCD.
REQ-029 reset asserted at bit_cnt=40 for 1 clk -> all outputs 0 next clk; sequence restarts, sample_ce 2*DIV clks after release.
REQ-030 DIV=1 -> sclk toggles every clk; sample_ce period 128 clks; REQ-026 bit pattern holds.
